parking_zone_tracker: RTL

PARKING_ZONE_TRACKER -- requirements
Module: parking_zone_tracker

---
 rtl/parking_pkg.sv | 21 ++
 rtl/req_edge_detect.sv | 19 +
 rtl/parking_zone_tracker.sv | 113 +++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants and types for the parking zone tracker
package parking_pkg;

  localparam int ZONE_CAP_DEFAULT = 4;
  localparam int NUM_ZONES        = 4;
  localparam int ZONE_W           = 2;
  localparam int CNT_W            = 3;

  typedef logic [ZONE_W-1:0] zone_t;
  typedef logic [CNT_W-1:0]  count_t;

  typedef enum logic {
    COLON_NORMAL,
    COLON_BLINK
  } colon_state_t;

  function automatic logic [3:0] to_digit(input count_t c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/req_edge_detect.sv
// rtl/req_edge_detect.sv - rising-edge detector for a level gate sensor
// The history flop resets high so a request held through reset must drop before it counts.
module req_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= req;
  end

  assign rise = req & ~prev;

endmodule

// File: rtl/parking_zone_tracker.sv
// rtl/parking_zone_tracker.sv - per-zone free-space counters, status pulses and full-lot colon blink
module parking_zone_tracker
  import parking_pkg::*;
#(
  parameter int ZONE_CAP  = ZONE_CAP_DEFAULT,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic [1:0] entry_zone,
  input  logic       exit_req,
  input  logic [1:0] exit_zone,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic       enable_colon,
  output logic       lot_full,
  output logic       entry_grant,
  output logic       entry_reject,
  output logic       exit_error
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam count_t CAP = count_t'(ZONE_CAP);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic         entry_ev;
  logic         exit_ev;
  logic         entry_ok;
  logic         exit_ok;
  logic         full_next;
  count_t       count      [NUM_ZONES];
  count_t       count_next [NUM_ZONES];
  colon_state_t state;
  logic [BW-1:0] blink_cnt;

  req_edge_detect u_entry_edge (
    .clk   (clk),
    .reset (reset),
    .req   (entry_req),
    .rise  (entry_ev)
  );

  req_edge_detect u_exit_edge (
    .clk   (clk),
    .reset (reset),
    .req   (exit_req),
    .rise  (exit_ev)
  );

  // Exit is applied first so a same-zone entry sees the space it frees.
  always_comb begin
    count_next = count;
    exit_ok    = exit_ev && (count[exit_zone] < CAP);
    if (exit_ok) count_next[exit_zone] = count[exit_zone] + count_t'(1);
    entry_ok   = entry_ev && (count_next[entry_zone] != '0);
    if (entry_ok) count_next[entry_zone] = count_next[entry_zone] - count_t'(1);
  end

  assign full_next = (count_next[0] == '0) && (count_next[1] == '0) &&
                     (count_next[2] == '0) && (count_next[3] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ZONES; i++) count[i] <= CAP;
      entry_grant  <= 1'b0;
      entry_reject <= 1'b0;
      exit_error   <= 1'b0;
      lot_full     <= 1'b0;
      state        <= COLON_NORMAL;
      blink_cnt    <= '0;
      enable_colon <= 1'b1;
    end else begin
      count        <= count_next;
      entry_grant  <= entry_ok;
      entry_reject <= entry_ev & ~entry_ok;
      exit_error   <= exit_ev & ~exit_ok;
      lot_full     <= full_next;
      case (state)
        COLON_NORMAL: begin
          enable_colon <= 1'b1;
          blink_cnt    <= '0;
          if (full_next) state <= COLON_BLINK;
        end
        COLON_BLINK: begin
          if (!full_next) begin
            state        <= COLON_NORMAL;
            enable_colon <= 1'b1;
            blink_cnt    <= '0;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt    <= '0;
            enable_colon <= ~enable_colon;
          end else begin
            blink_cnt    <= blink_cnt + 1'b1;
          end
        end
        default: begin
          state        <= COLON_NORMAL;
          enable_colon <= 1'b1;
          blink_cnt    <= '0;
        end
      endcase
    end
  end

  assign digit_0 = to_digit(count[0]);
  assign digit_1 = to_digit(count[1]);
  assign digit_2 = to_digit(count[2]);
  assign digit_3 = to_digit(count[3]);

endmodule
